// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and the counter-range helper used by the
// VGA sync generator.
package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int H_TOTAL  = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int V_TOTAL  = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
  localparam int HS_START = DEF_H_DISPLAY + DEF_H_FRONT;
  localparam int HS_END   = HS_START + DEF_H_SYNC;
  localparam int VS_START = DEF_V_DISPLAY + DEF_V_FRONT;
  localparam int VS_END   = VS_START + DEF_V_SYNC;

  // Half-open interval test: lo <= v < hi.
  function automatic logic in_range(input logic [CNT_W-1:0] v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) < hi);
  endfunction

endpackage

// File: rtl/divisor_pixel.sv
// Divides the system clock down to the pixel rate; tick is a combinational
// strobe on the last enabled cycle of each pixel period.
module divisor_pixel #(
  parameter int CLK_DIV = 4
) (
  input  logic reloj,
  input  logic resetM,
  input  logic enable,
  output logic tick
);

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

  logic [3:0] div_q, div_d;

  always_comb begin
    div_d = div_q;
    tick  = 1'b0;
    if (enable) begin
      if (div_q == DIV_LAST) begin
        tick  = 1'b1;
        div_d = '0;
      end else begin
        div_d = div_q + 4'd1;
      end
    end
  end

  always_ff @(posedge reloj or posedge resetM) begin
    if (resetM) div_q <= '0;
    else        div_q <= div_d;
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel/line counters plus sync, blanking and strobe
// qualifiers, all registered together so they never skew against Qh/Qv.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int H_DISPLAY   = DEF_H_DISPLAY,
  parameter int H_FRONT     = DEF_H_FRONT,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BACK      = DEF_H_BACK,
  parameter int V_DISPLAY   = DEF_V_DISPLAY,
  parameter int V_FRONT     = DEF_V_FRONT,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BACK      = DEF_V_BACK,
  parameter bit SYNC_ACTIVE = 1'b0
) (
  input  logic             reloj,
  input  logic             resetM,
  input  logic             enable,
  output logic [CNT_W-1:0] Qh,
  output logic [CNT_W-1:0] Qv,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic             pixel_tick,
  output logic             frame_start
);

  localparam int HS_START_P = H_DISPLAY + H_FRONT;
  localparam int HS_END_P   = HS_START_P + H_SYNC;
  localparam int VS_START_P = V_DISPLAY + V_FRONT;
  localparam int VS_END_P   = VS_START_P + V_SYNC;
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(HS_END_P + H_BACK - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(VS_END_P + V_BACK - 1);

  logic             tick;
  logic [CNT_W-1:0] qh_q, qh_d, qv_q, qv_d;
  logic             hsync_q, hsync_d, vsync_q, vsync_d;
  logic             video_on_q, video_on_d;
  logic             pixel_tick_q, frame_start_q, frame_start_d;

  divisor_pixel #(.CLK_DIV(CLK_DIV)) u_divisor_pixel (
    .reloj  (reloj),
    .resetM (resetM),
    .enable (enable),
    .tick   (tick)
  );

  // Qualifiers decode the next-state counters so they land on the same edge.
  always_comb begin
    qh_d          = qh_q;
    qv_d          = qv_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    video_on_d    = video_on_q;
    frame_start_d = 1'b0;
    if (tick) begin
      if (qh_q == H_LAST) begin
        qh_d = '0;
        qv_d = (qv_q == V_LAST) ? '0 : qv_q + 1'b1;
      end else begin
        qh_d = qh_q + 1'b1;
      end
      hsync_d       = in_range(qh_d, HS_START_P, HS_END_P) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync_d       = in_range(qv_d, VS_START_P, VS_END_P) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      video_on_d    = in_range(qh_d, 0, H_DISPLAY) && in_range(qv_d, 0, V_DISPLAY);
      frame_start_d = (qh_d == '0) && (qv_d == '0);
    end
  end

  always_ff @(posedge reloj or posedge resetM) begin
    if (resetM) begin
      qh_q          <= '0;
      qv_q          <= '0;
      hsync_q       <= ~SYNC_ACTIVE;
      vsync_q       <= ~SYNC_ACTIVE;
      video_on_q    <= 1'b0;
      pixel_tick_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      qh_q          <= qh_d;
      qv_q          <= qv_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      pixel_tick_q  <= tick;
      frame_start_q <= frame_start_d;
    end
  end

  assign Qh          = qh_q;
  assign Qv          = qv_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign pixel_tick  = pixel_tick_q;
  assign frame_start = frame_start_q;

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Generates 640x480@60 Hz VGA timing from the 100 MHz system clock.
- Outputs the pixel column/row counters Qh/Qv consumed by the downstream mosaic/character renderer.
- Also outputs hsync/vsync for the connector, plus video_on, pixel_tick and frame_start qualifiers.
- Sits directly upstream of the tile/font lookup stage; all counter and sync outputs are registered and mutually aligned.

Parameters:
- CLK_DIV, 4, reloj cycles per pixel (100 MHz -> 25 MHz pixel rate); legal range 1..16.
- H_DISPLAY, 640, visible pixels per line.
- H_FRONT, 16, horizontal front porch in pixels.
- H_SYNC, 96, hsync pulse width in pixels.
- H_BACK, 48, horizontal back porch in pixels.
- V_DISPLAY, 480, visible lines per frame.
- V_FRONT, 10, vertical front porch in lines.
- V_SYNC, 2, vsync pulse width in lines.
- V_BACK, 33, vertical back porch in lines.
- SYNC_ACTIVE, 0, active level of hsync/vsync (0 = active-low).

Ports:
- reloj  input  1  system clock, 100 MHz.
- resetM  input  1  asynchronous active-high reset.
- enable  input  1  when low, freezes all timing state.
- Qh  output  10  current pixel column, 0..H_TOTAL-1.
- Qv  output  10  current line, 0..V_TOTAL-1.
- hsync  output  1  horizontal sync, level set by SYNC_ACTIVE.
- vsync  output  1  vertical sync, level set by SYNC_ACTIVE.
- video_on  output  1  high when Qh<H_DISPLAY and Qv<V_DISPLAY.
- pixel_tick  output  1  one-reloj-cycle strobe marking each pixel advance.
- frame_start  output  1  one-reloj-cycle strobe when counters wrap to (0,0).

Behaviour:
- Derived values: H_TOTAL = sum of the H_* parameters = 800; V_TOTAL = sum of the V_* parameters = 525.
- Reset (async, resetM=1, applies mid-frame too):
  - divider = 0, Qh = 0, Qv = 0.
  - hsync = vsync = ~SYNC_ACTIVE.
  - video_on = 0, pixel_tick = 0, frame_start = 0.
  - Values hold while resetM is high.
- Divider:
  - Counter div, 0..CLK_DIV-1, increments each reloj edge while enable=1.
  - tick_int is asserted when div==CLK_DIV-1 and enable=1; div then wraps to 0.
  - With CLK_DIV=1, tick_int is high every enabled cycle.
- Counters, on the edge where tick_int=1:
  - Qh = Qh+1; if Qh==H_TOTAL-1, then Qh = 0 and the Qv step applies.
  - Qv step: Qv = Qv+1; if Qv==V_TOTAL-1, then Qv = 0.
  - Counter arithmetic is 10-bit unsigned; Qh and Qv never reach H_TOTAL or V_TOTAL.
- Registered qualifiers:
  - hsync, vsync and video_on are computed from the next-state counter values and registered on the same edge, so they are always consistent with the Qh/Qv presented (zero skew).
  - hsync is active when H_DISPLAY+H_FRONT <= Qh < H_DISPLAY+H_FRONT+H_SYNC, i.e. 656..751.
  - vsync is active when V_DISPLAY+V_FRONT <= Qv < V_DISPLAY+V_FRONT+V_SYNC, i.e. 490..491.
  - video_on is 0 from reset until the first tick; afterwards it follows the formula above.
- Strobes:
  - pixel_tick is a registered copy of tick_int: high for exactly one reloj cycle, on the cycle the new Qh/Qv appear.
  - frame_start is high for exactly one reloj cycle, coincident with the pixel_tick where (Qh,Qv) becomes (0,0) after a wrap.
  - frame_start is not asserted on reset release.
- enable=0:
  - div, Qh, Qv, hsync, vsync and video_on hold their values.
  - pixel_tick and frame_start are forced to 0.
  - On re-enable, counting resumes from the held div value; no tick is lost or duplicated.
- Latency: the first pixel_tick occurs CLK_DIV enabled edges after reset release, with Qh=1, Qv=0.
- Frame period: H_TOTAL*V_TOTAL*CLK_DIV = 1,680,000 enabled reloj cycles.

Decomposition:
- Package vga_timing_pkg holds:
  - the 640x480 timing constants;
  - derived H_TOTAL, V_TOTAL, HS_START, HS_END, VS_START, VS_END;
  - counter width (10).
- One sub-module, divisor_pixel, contains the CLK_DIV counter and tick_int generation, with ports reloj, resetM, enable, tick.
- The counters, sync decode and output registers stay in vga_sync_gen.

Test Plan:
- Reset check: assert resetM mid-line at Qh=300, Qv=100 -> same cycle Qh=0, Qv=0, hsync=vsync=1, video_on=0, pixel_tick=0; after release the first pixel_tick comes on the 4th edge, with Qh=1.
- Tick cadence: run 40 enabled cycles -> exactly 10 pixel_tick pulses, each 1 cycle wide, spaced 4 cycles; Qh steps 0->10.
- Line wrap: advance to Qh=799, Qv=5, then one tick -> Qh=0, Qv=6; hsync is 1 at Qh=655, 0 at 656 and 751, 1 at 752.
- Frame wrap: advance to Qh=799, Qv=524, then one tick -> Qh=0, Qv=0, frame_start=1 for one cycle; vsync is 0 only for Qv 490..491; measured frame = 1,680,000 cycles.
- Enable hold: drop enable at div=2, Qh=639, Qv=479 for 17 cycles -> all outputs held, no ticks; after re-enable the next tick comes 2 edges later with Qh=640, video_on=0.
- video_on boundaries: at Qh=639, Qv=479 video_on=1; at Qh=640 it is 0; at Qh=0, Qv=480 it is 0.
